// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared constants and types for the K=3, rate-1/2 Viterbi decoder control
// slice: code constraint length, trellis size, default traceback depth,
// path-metric width, normalisation threshold, pointer width, and the
// sequencing FSM state encoding.
package viterbi_pkg;

   localparam int K           = 3;
   localparam int NUM_STATES  = 4;
   localparam int DEPTH       = 15;
   localparam int PM_W        = 5;
   localparam int NORM_THRESH = 16;
   localparam int PTR_W       = $clog2(DEPTH);

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      TRACE = 2'd1,
      EMIT  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/viterbi_wrap_ctr.sv
// viterbi_wrap_ctr
// Modulo-DEPTH up/down counter with synchronous load. Used for the
// survivor-memory write pointer (counting up) and the traceback read
// pointer (counting down).
// Ports:
//   clk, rst    clock, asynchronous active-high reset (count resets to 0)
//   load_i      load load_val_i this cycle (wins over en_i)
//   load_val_i  value to load
//   en_i        advance the count by one step this cycle
//   up_i        1: count up, wrapping DEPTH-1 to 0; 0: count down, 0 to DEPTH-1
//   cnt_o       current count
module viterbi_wrap_ctr #(
   parameter int DEPTH = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic [$clog2(DEPTH)-1:0] load_val_i,
   input  logic                     en_i,
   input  logic                     up_i,
   output logic [$clog2(DEPTH)-1:0] cnt_o
);

   localparam int W = $clog2(DEPTH);
   localparam logic [W-1:0] TOP = W'(DEPTH - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, modulo step up/down, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            if (cnt_q == TOP) begin
               cnt_d = {W{1'b0}};
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end else begin
            if (cnt_q == {W{1'b0}}) begin
               cnt_d = TOP;
            end else begin
               cnt_d = cnt_q - W'(1);
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl
// Sequencing controller for a K=3, rate-1/2 Viterbi decoder datapath.
// Accepts 2-bit symbols on a valid/ready handshake, fires one ACS step per
// accepted symbol, keeps the circular survivor write pointer, flags metric
// normalisation, and once the window holds DEPTH columns runs a full-depth
// traceback after each symbol, emitting one decoded bit per traceback.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   sym_valid/sym_ready/sym_in   symbol handshake and payload
//   frame_start                  accepted symbol starts a new frame
//   acs_en/acs_sym/acs_init      ACS strobe, its symbol, metric seeding
//   wr_addr                      survivor column written by this ACS
//   pm_min/norm_en               minimum metric in, normalise strobe out
//   best_state                   state holding the minimum metric
//   tb_rd_addr/tb_state/tb_dec   traceback survivor read port
//   out_valid/out_bit            decoded bit (one-cycle pulse)
module viterbi_ctrl
   import viterbi_pkg::*;
#(
   parameter int DEPTH       = viterbi_pkg::DEPTH,
   parameter int PM_W        = viterbi_pkg::PM_W,
   parameter int NORM_THRESH = viterbi_pkg::NORM_THRESH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sym_valid,
   output logic                     sym_ready,
   input  logic [1:0]               sym_in,
   input  logic                     frame_start,
   output logic                     acs_en,
   output logic [1:0]               acs_sym,
   output logic                     acs_init,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [PM_W-1:0]          pm_min,
   output logic                     norm_en,
   input  logic [1:0]               best_state,
   output logic [$clog2(DEPTH)-1:0] tb_rd_addr,
   output logic [1:0]               tb_state,
   input  logic                     tb_dec,
   output logic                     out_valid,
   output logic                     out_bit
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_STEP = AW'(DEPTH - 1);
   localparam logic [FW-1:0] FULL      = FW'(DEPTH);

   ctrl_state_t   state_q;
   logic [AW-1:0] step_q;
   logic [FW-1:0] fill_q;
   logic [FW-1:0] fill_d;
   logic [1:0]    tb_state_q;
   logic [1:0]    tb_cur_s;
   logic          sym_ready_q;
   logic          out_valid_q;
   logic          out_bit_q;
   logic          hs_s;
   logic          init_s;
   logic          full_d_s;
   logic          trace_s;
   logic [AW-1:0] wr_addr_s;
   logic [AW-1:0] wptr_s;
   logic [AW-1:0] tb_ptr_s;

   // Handshake decode, write column selection and fill-level update.
   always_comb begin
      hs_s    = sym_valid & sym_ready_q;
      trace_s = (state_q == TRACE);
      // An empty window or a new frame restarts the trellis at column 0.
      init_s  = frame_start | (fill_q == {FW{1'b0}});
      if (init_s) begin
         wr_addr_s = {AW{1'b0}};
         fill_d    = FW'(1);
      end else begin
         wr_addr_s = wptr_s;
         if (fill_q == FULL) begin
            fill_d = FULL;
         end else begin
            fill_d = fill_q + FW'(1);
         end
      end
      full_d_s = (fill_d == FULL);
   end

   // Traceback state presented to the survivor memory: the first step starts
   // from the best state of the just-updated metrics, later steps follow the
   // registered chain.
   always_comb begin
      if (trace_s && (step_q == {AW{1'b0}})) begin
         tb_cur_s = best_state;
      end else begin
         tb_cur_s = tb_state_q;
      end
   end

   // Write pointer: restarts at 1 after a seeding write, otherwise advances.
   viterbi_wrap_ctr #(.DEPTH(DEPTH)) u_wptr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (hs_s & init_s),
      .load_val_i (AW'(1)),
      .en_i       (hs_s),
      .up_i       (1'b1),
      .cnt_o      (wptr_s)
   );

   // Traceback pointer: captures the newest column on every accepted symbol
   // and walks backwards through the window during TRACE.
   viterbi_wrap_ctr #(.DEPTH(DEPTH)) u_tb_ptr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (hs_s),
      .load_val_i (wr_addr_s),
      .en_i       (trace_s),
      .up_i       (1'b0),
      .cnt_o      (tb_ptr_s)
   );

   // Sequencing FSM with registered ready/valid/bit outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= WAIT;
         step_q      <= {AW{1'b0}};
         fill_q      <= {FW{1'b0}};
         tb_state_q  <= 2'b00;
         sym_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         if (hs_s) begin
            fill_q <= fill_d;
         end
         case (state_q)
            WAIT: begin
               if (hs_s && full_d_s) begin
                  state_q     <= TRACE;
                  step_q      <= {AW{1'b0}};
                  sym_ready_q <= 1'b0;
               end
            end
            TRACE: begin
               // Predecessor state: shift in the survivor decision bit.
               tb_state_q <= {tb_cur_s[0], tb_dec};
               if (step_q == LAST_STEP) begin
                  out_bit_q   <= tb_cur_s[1];
                  out_valid_q <= 1'b1;
                  sym_ready_q <= 1'b1;
                  step_q      <= {AW{1'b0}};
                  state_q     <= EMIT;
               end else begin
                  step_q <= step_q + AW'(1);
               end
            end
            EMIT: begin
               out_valid_q <= 1'b0;
               if (hs_s && full_d_s) begin
                  state_q     <= TRACE;
                  step_q      <= {AW{1'b0}};
                  sym_ready_q <= 1'b0;
               end else begin
                  state_q     <= WAIT;
                  sym_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= WAIT;
               step_q      <= {AW{1'b0}};
               sym_ready_q <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign sym_ready  = sym_ready_q;
   assign acs_en     = hs_s;
   assign acs_sym    = sym_in;
   assign acs_init   = hs_s & init_s;
   assign wr_addr    = wr_addr_s;
   assign norm_en    = hs_s & (pm_min >= PM_W'(NORM_THRESH));
   assign tb_rd_addr = tb_ptr_s;
   assign tb_state   = tb_cur_s;
   assign out_valid  = out_valid_q;
   assign out_bit    = out_bit_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl
// Directed self-checking bench for viterbi_ctrl: reset values, window fill,
// pointer wrap, traceback chains, normalisation and reset during traceback.
module tb_viterbi_ctrl;

   localparam int DEPTH = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_valid;
   logic       sym_ready;
   logic [1:0] sym_in;
   logic       frame_start;
   logic       acs_en;
   logic [1:0] acs_sym;
   logic       acs_init;
   logic [3:0] wr_addr;
   logic [4:0] pm_min;
   logic       norm_en;
   logic [1:0] best_state;
   logic [3:0] tb_rd_addr;
   logic [1:0] tb_state;
   logic       tb_dec;
   logic       out_valid;
   logic       out_bit;

   int checks   = 0;
   int failures = 0;

   viterbi_ctrl #(.DEPTH(15), .PM_W(5), .NORM_THRESH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .sym_valid   (sym_valid),
      .sym_ready   (sym_ready),
      .sym_in      (sym_in),
      .frame_start (frame_start),
      .acs_en      (acs_en),
      .acs_sym     (acs_sym),
      .acs_init    (acs_init),
      .wr_addr     (wr_addr),
      .pm_min      (pm_min),
      .norm_en     (norm_en),
      .best_state  (best_state),
      .tb_rd_addr  (tb_rd_addr),
      .tb_state    (tb_state),
      .tb_dec      (tb_dec),
      .out_valid   (out_valid),
      .out_bit     (out_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One handshake starting just after a rising edge; returns just after the next one.
   task automatic hs(input logic [1:0] s, input logic fs, input logic [4:0] pm,
                     input logic [3:0] ewa, input logic einit, input logic enorm);
      sym_valid   = 1'b1;
      sym_in      = s;
      frame_start = fs;
      pm_min      = pm;
      #1;
      chk("hs_ready", sym_ready, 1'b1);
      chk("acs_en", acs_en, 1'b1);
      chk("acs_sym", acs_sym, s);
      chk("acs_init", acs_init, einit);
      chk("wr_addr", wr_addr, ewa);
      chk("norm_en", norm_en, enorm);
      @(posedge clk); #1;
      sym_valid   = 1'b0;
      frame_start = 1'b0;
      pm_min      = 5'd0;
      sym_in      = 2'b00;
   endtask

   // Follows a full traceback from its first cycle through the EMIT cycle.
   task automatic run_trace(input logic [3:0] start, input logic [1:0] bs, input logic dec);
      logic [1:0] st;
      logic [3:0] addr;
      logic       ob;
      st         = bs;
      addr       = start;
      ob         = 1'b0;
      best_state = bs;
      tb_dec     = dec;
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("trace_ready", sym_ready, 1'b0);
         chk("trace_ovalid", out_valid, 1'b0);
         chk("trace_acs_en", acs_en, 1'b0);
         chk("tb_rd_addr", tb_rd_addr, addr);
         chk("tb_state", tb_state, st);
         if (i == DEPTH - 1) ob = st[1];
         st   = {st[0], dec};
         addr = (addr == 4'd0) ? 4'd14 : addr - 4'd1;
         @(posedge clk); #1;
      end
      chk("emit_valid", out_valid, 1'b1);
      chk("emit_bit", out_bit, ob);
      chk("emit_ready", sym_ready, 1'b1);
   endtask

   initial begin
      rst         = 1'b1;
      sym_valid   = 1'b0;
      sym_in      = 2'b00;
      frame_start = 1'b0;
      pm_min      = 5'd0;
      best_state  = 2'b00;
      tb_dec      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", sym_ready, 1'b1);
      chk("rst_ovalid", out_valid, 1'b0);
      chk("rst_obit", out_bit, 1'b0);
      chk("rst_acs_en", acs_en, 1'b0);
      chk("rst_acs_init", acs_init, 1'b0);
      chk("rst_norm", norm_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 4'd0);
      chk("rst_tb_rd", tb_rd_addr, 4'd0);
      chk("rst_tb_state", tb_state, 2'b00);
      rst = 1'b0;

      // Fill: first symbol seeds without frame_start, then a new frame of 15.
      hs(2'b00, 1'b0, 5'd0, 4'd0, 1'b1, 1'b0);
      hs(2'b00, 1'b1, 5'd0, 4'd0, 1'b1, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         hs(2'b00, 1'b0, 5'd0, 4'(i), 1'b0, 1'b0);
      end
      run_trace(4'd14, 2'b00, 1'b0);
      @(posedge clk); #1;
      chk("post_emit_ovalid", out_valid, 1'b0);

      // Wrap to column 0, normalise at threshold, state chain 10 -> 00.
      hs(2'b11, 1'b0, 5'd16, 4'd0, 1'b0, 1'b1);
      run_trace(4'd0, 2'b10, 1'b0);
      @(posedge clk); #1;

      // Just below threshold, chain held at 11 -> decoded 1.
      hs(2'b01, 1'b0, 5'd15, 4'd1, 1'b0, 1'b0);
      run_trace(4'd1, 2'b11, 1'b1);

      // Handshake accepted during EMIT; chain 01 -> 10 -> 00.
      hs(2'b10, 1'b0, 5'd0, 4'd2, 1'b0, 1'b0);
      run_trace(4'd2, 2'b01, 1'b0);
      @(posedge clk); #1;
      chk("wait_ovalid", out_valid, 1'b0);
      chk("wait_ready", sym_ready, 1'b1);

      // Large metric with no symbol offered: no normalisation.
      pm_min = 5'd20;
      #1;
      chk("idle_norm", norm_en, 1'b0);
      chk("idle_acs_en", acs_en, 1'b0);
      pm_min = 5'd0;
      @(posedge clk); #1;

      // Reset at traceback step 7.
      best_state = 2'b00;
      tb_dec     = 1'b0;
      hs(2'b00, 1'b0, 5'd0, 4'd3, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      chk("step7_tb_rd", tb_rd_addr, 4'd11);
      chk("step7_ready", sym_ready, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_ready", sym_ready, 1'b1);
      chk("midrst_ovalid", out_valid, 1'b0);
      chk("midrst_tb_rd", tb_rd_addr, 4'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("no_ovalid_after_rst", out_valid, 1'b0);
         chk("ready_after_rst", sym_ready, 1'b1);
         @(posedge clk); #1;
      end

      // Refill needs 15 symbols, first one seeds at column 0.
      hs(2'b00, 1'b0, 5'd0, 4'd0, 1'b1, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         hs(2'b00, 1'b0, 5'd0, 4'(i), 1'b0, 1'b0);
      end
      run_trace(4'd14, 2'b01, 1'b1);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
